// File: rtl/sipo_deser_if.sv
// Word-side and bit-side signals of the serial-in/parallel-out deserialiser.
// Handshake: serial_in is taken on an edge where in_valid=1 (no ready on the
// bit side). A held word moves to the consumer on an edge where par_valid=1
// and par_ready=1; par_valid is registered and never depends on par_ready.
interface sipo_deser_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             serial_in;
   logic             par_ready;
   logic             par_valid;
   logic [WIDTH-1:0] parallel_out;

   // Environment side: drives bits and consumes words.
   modport master (
      output in_valid,
      output serial_in,
      output par_ready,
      input  par_valid,
      input  parallel_out
   );

   // Deserialiser side.
   modport slave (
      input  in_valid,
      input  serial_in,
      input  par_ready,
      output par_valid,
      output parallel_out
   );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser. A shift stage collects WIDTH bits while
// a separate holding stage presents the last completed word, so shifting never
// stalls on the consumer. A word completing while the holding stage is still
// occupied and not being accepted is dropped and flagged by a one-cycle
// overrun pulse.
module sipo_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   sipo_deser_if.slave   bus,
   output logic [CW-1:0] bit_count,
   output logic          overrun
);

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] shifted;
   logic             take;
   logic             last_bit;
   logic             complete;
   logic             accept;
   logic             load;
   logic             drop;

   // Next shift-register value if the current bit is taken; also the
   // completed word when this bit finishes one.
   always_comb begin
      shifted = sreg;
      if (MSB_FIRST) begin
         shifted = {sreg[WIDTH-2:0], bus.serial_in};
      end else begin
         shifted = {bus.serial_in, sreg[WIDTH-1:1]};
      end
   end

   // Event decode: a clear swallows any bit on the same edge, so it can
   // never complete a word.
   always_comb begin
      take     = bus.in_valid && !clear;
      last_bit = (bit_count == CW'(WIDTH - 1));
      complete = take && last_bit;
      accept   = bus.par_valid && bus.par_ready;
      load     = complete && (!bus.par_valid || bus.par_ready);
      drop     = complete && bus.par_valid && !bus.par_ready;
   end

   // Shift stage: partial word and its bit count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg      <= '0;
         bit_count <= '0;
      end else if (clear) begin
         sreg      <= '0;
         bit_count <= '0;
      end else if (take) begin
         sreg      <= shifted;
         bit_count <= last_bit ? '0 : bit_count + CW'(1);
      end
   end

   // Holding stage: load on completion when free or being emptied this edge;
   // otherwise an accept empties it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.parallel_out <= '0;
         bus.par_valid    <= 1'b0;
      end else if (load) begin
         bus.parallel_out <= shifted;
         bus.par_valid    <= 1'b1;
      end else if (accept) begin
         bus.par_valid    <= 1'b0;
      end
   end

   // Overrun pulse: high for the cycle after a completed word was dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else begin
         overrun <= drop;
      end
   end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser. Two instances, MSB-first and LSB-first, see
// the same bit stream; the LSB-first word is the bit-reverse of the MSB-first.
module tb_sipo_deser;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       in_valid;
   logic       serial_in;
   logic       par_ready;
   logic [2:0] bc_m;
   logic [2:0] bc_l;
   logic       ov_m;
   logic       ov_l;

   int test_count = 0;
   int fail_count = 0;

   sipo_deser_if #(.WIDTH(8)) bus_m ();
   sipo_deser_if #(.WIDTH(8)) bus_l ();

   assign bus_m.in_valid  = in_valid;
   assign bus_m.serial_in = serial_in;
   assign bus_m.par_ready = par_ready;
   assign bus_l.in_valid  = in_valid;
   assign bus_l.serial_in = serial_in;
   assign bus_l.par_ready = par_ready;

   sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .bus       (bus_m),
      .bit_count (bc_m),
      .overrun   (ov_m)
   );

   sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .bus       (bus_l),
      .bit_count (bc_l),
      .overrun   (ov_l)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Run-time guard
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string tag, input logic pv, input logic [7:0] w, input logic ov);
      check({tag, " pv_m"},  32'(bus_m.par_valid), 32'(pv));
      check({tag, " pv_l"},  32'(bus_l.par_valid), 32'(pv));
      check({tag, " out_m"}, 32'(bus_m.parallel_out), 32'(w));
      check({tag, " out_l"}, 32'(bus_l.parallel_out), 32'(rev8(w)));
      check({tag, " ov_m"},  32'(ov_m), 32'(ov));
      check({tag, " ov_l"},  32'(ov_l), 32'(ov));
   endtask

   task automatic send_word(input logic [7:0] w, input bit gap, input bit ready_last);
      for (int i = 7; i >= 0; i--) begin
         if (gap) begin
            in_valid = 1'b0;
            step();
         end
         serial_in = w[i];
         in_valid  = 1'b1;
         if (ready_last && i == 0) par_ready = 1'b1;
         step();
         if (ready_last && i == 0) par_ready = 1'b0;
      end
      in_valid = 1'b0;
   endtask

   // Directed sequence
   initial begin
      logic [7:0] w;
      rst       = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      serial_in = 1'b0;
      par_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_both("reset", 1'b0, 8'h00, 1'b0);
      check("reset bc_m", 32'(bc_m), 32'd0);
      check("reset bc_l", 32'(bc_l), 32'd0);
      step();
      step();
      rst = 1'b1;

      // 1/2: MSB-first and LSB-first, bit_count stepping 1..7 then 0
      par_ready = 1'b1;
      w = 8'hC0;
      for (int k = 0; k < 8; k++) begin
         serial_in = w[7-k];
         in_valid  = 1'b1;
         step();
         check("t1 bc_m", 32'(bc_m), 32'((k + 1) % 8));
         check("t1 bc_l", 32'(bc_l), 32'((k + 1) % 8));
      end
      in_valid = 1'b0;
      check_both("t1 word", 1'b1, 8'hC0, 1'b0);
      step();
      check("t1 accepted pv_m", 32'(bus_m.par_valid), 32'd0);

      // 3: gaps freeze bit_count
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b0;
         step();
         check("t3 gap bc_m", 32'(bc_m), 32'(k));
         serial_in = w[7-k];
         in_valid  = 1'b1;
         step();
         check("t3 bc_m", 32'(bc_m), 32'((k + 1) % 8));
      end
      in_valid = 1'b0;
      check_both("t3 word", 1'b1, 8'hC0, 1'b0);
      step();
      check("t3 accepted pv_m", 32'(bus_m.par_valid), 32'd0);

      // 4: overrun
      par_ready = 1'b0;
      send_word(8'hC0, 1'b0, 1'b0);
      check_both("t4 first", 1'b1, 8'hC0, 1'b0);
      send_word(8'hFF, 1'b0, 1'b0);
      check_both("t4 overrun", 1'b1, 8'hC0, 1'b1);
      par_ready = 1'b1;
      step();
      check_both("t4 drained", 1'b0, 8'hC0, 1'b0);

      // 5: back-to-back load on the accepting edge
      par_ready = 1'b0;
      send_word(8'hC0, 1'b0, 1'b0);
      check_both("t5 first", 1'b1, 8'hC0, 1'b0);
      send_word(8'h5A, 1'b0, 1'b1);
      check_both("t5 b2b", 1'b1, 8'h5A, 1'b0);
      step();
      check_both("t5 hold", 1'b1, 8'h5A, 1'b0);
      par_ready = 1'b1;
      step();
      check("t5 accepted pv_m", 32'(bus_m.par_valid), 32'd0);

      // 6a: clear after 3 bits, then a fresh word
      for (int k = 0; k < 3; k++) begin
         serial_in = k[0] ? 1'b0 : 1'b1;
         in_valid  = 1'b1;
         step();
      end
      check("t6 bc3", 32'(bc_m), 32'd3);
      clear     = 1'b1;
      serial_in = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t6 cleared bc_m", 32'(bc_m), 32'd0);
      check("t6 cleared bc_l", 32'(bc_l), 32'd0);
      send_word(8'hA5, 1'b0, 1'b0);
      par_ready = 1'b0;
      check_both("t6 word", 1'b1, 8'hA5, 1'b0);

      // 6b: clear on what would be the completing bit, holding register full
      for (int k = 0; k < 7; k++) begin
         serial_in = 1'b1;
         in_valid  = 1'b1;
         step();
      end
      check("t6 bc7", 32'(bc_m), 32'd7);
      clear = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t6 clr7 bc_m", 32'(bc_m), 32'd0);
      check_both("t6 clr7 hold", 1'b1, 8'hA5, 1'b0);

      // 6c: asynchronous reset mid-word with a held word
      for (int k = 0; k < 2; k++) begin
         serial_in = 1'b1;
         in_valid  = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("t6 bc2", 32'(bc_m), 32'd2);
      #2 rst = 1'b0;
      #1;
      check_both("t6 async rst", 1'b0, 8'h00, 1'b0);
      check("t6 async rst bc_m", 32'(bc_m), 32'd0);
      check("t6 async rst bc_l", 32'(bc_l), 32'd0);
      step();
      rst       = 1'b1;
      par_ready = 1'b1;
      send_word(8'h0D, 1'b0, 1'b0);
      check_both("t6 after rst", 1'b1, 8'h0D, 1'b0);
      check("t6 after rst bc_m", 32'(bc_m), 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
